// File: rtl/timer_peripheral_if.sv
// Data-bus bundle shared by the pipeline's MEM stage and memory-mapped
// peripherals: address, store data, strobes and the OR-merged readback.
interface timer_peripheral_if;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;

    // Pipeline side: issues loads/stores and consumes readback
    modport master (
        output Address,
        output Write_data,
        output MemWrite,
        output MemRead,
        input  Read_data
    );

    // Peripheral side: decodes the access and returns readback
    modport slave (
        input  Address,
        input  Write_data,
        input  MemWrite,
        input  MemRead,
        output Read_data
    );
endinterface

// File: rtl/timer_peripheral.sv
// Memory-mapped timer (TH/TL/TCON) with prescaler and a free-running
// SYSTICK counter. Readback is combinational so it can be OR-merged into
// the data-memory load mux; irq is a registered level request.
module timer_peripheral #(
    parameter int PRESCALE = 1,
    parameter int PS_BITS  = 16
) (
    input  logic                clk,
    input  logic                reset,
    timer_peripheral_if.slave   bus,
    output logic                irq
);

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam logic [PS_BITS-1:0] PS_MAX = PS_BITS'(PRESCALE - 1);
    localparam logic [PS_BITS-1:0] PS_ONE = PS_BITS'(1);
    localparam logic [31:0]        TL_MAX = 32'hFFFF_FFFF;

    // The FSM state is the EN bit: COUNT means the prescaler is running.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t              state_r;
    logic [PS_BITS-1:0]  ps_cnt_r;
    logic [31:0]         th_r;
    logic [31:0]         tl_r;
    logic [31:0]         systick_r;
    logic                ie_r;
    logic                if_r;
    logic                irq_r;

    logic                wr_th_s;
    logic                wr_tl_s;
    logic                wr_tcon_s;
    logic                wr_sys_s;
    logic                disable_s;
    logic                tick_s;
    logic                do_tick_s;
    logic                ovf_s;
    logic                ie_next_s;
    logic                if_next_s;
    logic [31:0]         rd_s;

    // Address decode, tick qualification and next IE/IF with set-priority on IF
    always_comb begin
        wr_th_s   = bus.MemWrite && (bus.Address == ADDR_TH);
        wr_tl_s   = bus.MemWrite && (bus.Address == ADDR_TL);
        wr_tcon_s = bus.MemWrite && (bus.Address == ADDR_TCON);
        wr_sys_s  = bus.MemWrite && (bus.Address == ADDR_SYSTICK);
        // A TCON write that clears EN beats a tick landing in the same cycle.
        disable_s = wr_tcon_s && !bus.Write_data[0];
        tick_s    = (state_r == ST_COUNT) && (ps_cnt_r == PS_MAX);
        // A software TL write also beats the tick: no increment, no reload.
        do_tick_s = tick_s && !wr_tl_s && !disable_s;
        ovf_s     = do_tick_s && (tl_r == TL_MAX);
        if (wr_tcon_s) begin
            ie_next_s = bus.Write_data[1];
            if_next_s = bus.Write_data[2] | ovf_s;
        end else begin
            ie_next_s = ie_r;
            if_next_s = if_r | ovf_s;
        end
    end

    // Combinational readback; zero when unmapped, not reading, or in reset
    always_comb begin
        rd_s = 32'h0000_0000;
        if (!reset || !bus.MemRead) begin
            rd_s = 32'h0000_0000;
        end else begin
            case (bus.Address)
                ADDR_TH:      rd_s = th_r;
                ADDR_TL:      rd_s = tl_r;
                ADDR_TCON:    rd_s = {29'd0, if_r, ie_r, (state_r == ST_COUNT)};
                ADDR_SYSTICK: rd_s = systick_r;
                default:      rd_s = 32'h0000_0000;
            endcase
        end
    end

    assign bus.Read_data = rd_s;
    assign irq           = irq_r;

    // Enable FSM and prescale counter: counts 0..PRESCALE-1 only while COUNT
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            ps_cnt_r <= {PS_BITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ps_cnt_r <= {PS_BITS{1'b0}};
                    if (wr_tcon_s && bus.Write_data[0]) begin
                        state_r <= ST_COUNT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (disable_s) begin
                        state_r  <= ST_IDLE;
                        ps_cnt_r <= {PS_BITS{1'b0}};
                    end else if (tick_s) begin
                        state_r  <= ST_COUNT;
                        ps_cnt_r <= {PS_BITS{1'b0}};
                    end else begin
                        state_r  <= ST_COUNT;
                        ps_cnt_r <= ps_cnt_r + PS_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ps_cnt_r <= {PS_BITS{1'b0}};
                end
            endcase
        end
    end

    // Timer registers: software writes first, then tick-driven increment/reload
    always_ff @(posedge clk) begin
        if (!reset) begin
            th_r <= 32'h0000_0000;
            tl_r <= 32'h0000_0000;
            ie_r <= 1'b0;
            if_r <= 1'b0;
        end else begin
            // Reload reads th_r before this cycle's TH write lands.
            if (wr_th_s) begin
                th_r <= bus.Write_data;
            end else begin
                th_r <= th_r;
            end
            if (wr_tl_s) begin
                tl_r <= bus.Write_data;
            end else if (ovf_s) begin
                tl_r <= th_r;
            end else if (do_tick_s) begin
                tl_r <= tl_r + 32'd1;
            end else begin
                tl_r <= tl_r;
            end
            ie_r <= ie_next_s;
            if_r <= if_next_s;
        end
    end

    // Free-running system tick; a store overrides the increment
    always_ff @(posedge clk) begin
        if (!reset) begin
            systick_r <= 32'h0000_0000;
        end else if (wr_sys_s) begin
            systick_r <= bus.Write_data;
        end else begin
            systick_r <= systick_r + 32'd1;
        end
    end

    // Level interrupt, asserted the cycle after an overflow when enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ie_next_s & if_next_s;
        end
    end

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
- Memory-mapped timer and system-tick counter on the same data bus as the data memory and its LED/digit registers.
- Decodes 0x40000000–0x40000008 (TH, TL, TCON) and 0x40000014 (SYSTICK).
- Returns readback data that is OR-merged into the data-memory read mux.
- Raises a level interrupt request to the pipeline's exception/PC-select logic.

Parameters:
PRESCALE, 1, clk cycles per TL increment; legal range 1..65535
PS_BITS, 16, width of the internal prescale counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
Address  input  32  byte address from the EX/MEM stage
Write_data  input  32  store data
MemWrite  input  1  store strobe, sampled on the clk edge
MemRead  input  1  load strobe, combinational readback
Read_data  output  32  readback; 0 when the address is unmapped, MemRead=0, or reset=0
irq  output  1  interrupt request, level, registered

Behaviour:
Reset (reset=0 at a clk edge):
- TH, TL, TCON, SYSTICK and the prescale counter are all cleared to 0.
- irq=0 from the following cycle.
- Read_data is forced to 0 combinationally while reset=0.
- A reset arriving mid-count discards all count state. No partial overflow is retained.

Register map:
- 0x40000000 TH: 32-bit reload value, R/W.
- 0x40000004 TL: 32-bit counter, R/W.
- 0x40000008 TCON: bits[2:0] R/W, upper bits read 0.
  - [0] EN: timer enable.
  - [1] IE: interrupt enable.
  - [2] IF: overflow flag.
- 0x40000014 SYSTICK: 32-bit free-running counter, R/W.
- Addresses are decoded with full 32-bit compare. Misaligned and other addresses are ignored on write and read as 0.

Read path:
- Read_data = MemRead ? selected register : 0.
- Purely combinational, zero-latency, matching the data-memory load timing.

SYSTICK:
- Increments by 1 every clk, wrapping 0xFFFFFFFF -> 0.
- A write loads Write_data and takes priority over the increment in that cycle.

Prescaler:
- While EN=1, ps_cnt counts 0..PRESCALE-1. A tick is asserted in the cycle where ps_cnt==PRESCALE-1, and ps_cnt then returns to 0.
- While EN=0, ps_cnt is held at 0.
- With PRESCALE=1, a tick occurs every cycle.

Timer, on a tick:
- If TL==0xFFFFFFFF: TL<=TH (reload) and IF<=1.
- Otherwise: TL<=TL+1.

Simultaneous events:
- Software write to TL in a tick cycle: the write wins, and no overflow or reload occurs that cycle.
- Software write to TH in an overflow cycle: the reload uses the old TH. The new TH takes effect from the next cycle.
- Write to TCON clearing IF in the same cycle as an overflow: IF ends at 1, so the set wins and no interrupt is lost.
- Write to TCON setting EN=0 in a tick cycle: the write wins. No increment occurs and ps_cnt clears.

irq:
- Registered: irq <= IE & IF_next, i.e. it asserts one cycle after the overflow edge.
- Held until software clears IF or IE.

State machine (controls ps_cnt/EN interaction only):
- IDLE (EN=0) -> COUNT on a write with EN=1.
- COUNT -> IDLE on a write with EN=0 or on reset.

Test Plan:
- Reset held low for 2 cycles with MemRead=1 at 0x40000014 -> Read_data=0. After release SYSTICK reads 0, then 1, 2, 3 on successive cycles; irq=0.
- PRESCALE=1; write TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 -> TL reads FFFFFFFF, then FFFFFFFC (reload). TCON reads 7 and irq=1 one cycle after the reload edge; TL continues FFFFFFFD.
- Write TCON=3 (clear IF) in the exact cycle of an overflow -> TCON reads 7 afterwards and irq stays 1. A later write of TCON=3 with no overflow -> irq drops to 0 the following cycle.
- PRESCALE=4, EN=1, TL=0 -> TL reads 1 after 4 cycles and 2 after 8. Write TCON=0 mid-period, then TCON=1 again -> the next increment comes exactly 4 cycles after re-enable.
- IE=0 overflow -> IF=1 and irq stays 0. Then write TCON=7 -> irq=1 next cycle.
- Write and read 0x4000000C, 0x40000018 and 0x40000002 -> Read_data=0 and no timer register changes. MemRead=0 at 0x40000004 -> Read_data=0.
